f1_light_seq: RTL
=================

Name: f1_light_seq

Overview:
- Parametrised start-light sequencer for the F1 reaction-game datapath.
- On a start trigger, lights WIDTH lamps one per enable tick, then holds all lamps on for a fixed or pseudo-random delay.
- After the delay, extinguishes all lamps and emits a one-cycle go pulse that starts the downstream reaction timer.
- Also supports abort, busy indication and an internal free-running LFSR for random hold delays.

Parameters:
- WIDTH, 8, number of lamps / width of out (1..32).
- DLY_W, 7, width of the hold-delay value in clk cycles (1..16).
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  lamp-advance tick; qualifies FILL progress only.
- trigger  input  1  start request; sampled in IDLE only.
- abort  input  1  cancel the sequence, return to IDLE.
- rnd_mode  input  1  1 = hold delay from LFSR, 0 = from delay_in.
- delay_in  input  DLY_W  fixed hold delay, in clk cycles.
- out  output  WIDTH  lamp vector; lamp i lit = bit i.
- busy  output  1  high in any state other than IDLE.
- go  output  1  one-cycle lights-out pulse.

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high; there is no asynchronous reset.
- Outputs are Moore outputs: out, busy and go decode registered state only, with no combinational path from any input.
- Reset, taking effect at the clk edge where rst=1:
  - state=IDLE, lit=0, hold_cnt=0, lfsr=SEED (or 1 if SEED=0).
  - out=0, busy=0, go=0.
- rst overrides all other inputs. Reset mid-sequence drops to IDLE without a go pulse.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clk cycle regardless of state; frozen only during rst.
  - Never reaches zero.
- Random delay = lfsr[DLY_W-1:0], sampled on FILL->HOLD entry.
- States:
  - IDLE: out=0, busy=0.
    - trigger=1 -> FILL with lit=0.
    - en is ignored, including en=1 in the same cycle as trigger.
  - FILL: out = lowest lit bits set ({WIDTH-lit zeros, lit ones}).
    - Each cycle with en=1 increments lit.
    - When en=1 and lit==WIDTH-1: lit becomes WIDTH and the state moves to HOLD.
    - On that same edge hold_cnt loads rnd_mode ? lfsr[DLY_W-1:0] : delay_in.
  - HOLD: out = all ones.
    - If hold_cnt==0 -> GO; else hold_cnt decrements every clk cycle, independent of en.
    - HOLD therefore lasts D+1 cycles for delay D; D=0 gives 1 cycle.
    - delay_in and rnd_mode changes during HOLD have no effect.
  - GO: out=0, go=1, busy=1 for exactly one cycle, then IDLE with lit=0.
- Abort:
  - abort=1 in FILL or HOLD -> IDLE on the next edge, out=0, no go pulse.
  - abort=1 in GO: GO completes normally.
  - abort=1 in IDLE: no effect.
  - abort beats en and hold expiry when they occur in the same cycle.
- trigger outside IDLE is ignored; it is not queued.
- trigger and abort together in IDLE: the sequence starts.
- WIDTH=1: the first en in FILL moves straight to HOLD; out goes 0 -> 1.
- Width rules:
  - lit counter is $clog2(WIDTH+1) bits.
  - hold_cnt is DLY_W bits, unsigned, and never wraps (decrement is gated at 0).
- Sequence latency from trigger (fixed mode, en held high):
  - out all ones WIDTH+1 edges after the trigger edge.
  - go high WIDTH+D+2 edges after the trigger edge.

Test Plan:
- Reset/idle: assert rst 2 cycles with trigger=1 -> out=0, busy=0, go=0; trigger after rst release starts FILL on the next edge.
- Fixed sequence, WIDTH=8, delay_in=5, en held high:
  - out steps 00,01,03,07,0F,1F,3F,7F,FF on successive cycles after trigger.
  - FF held 6 cycles, then go=1 for one cycle with out=00, then busy=0.
- Sparse en (one pulse every 4 cycles): out advances only on en cycles; hold duration stays 6 cycles; en pulses during HOLD do not change timing.
- Abort at out=0F and again mid-HOLD: next cycle out=00, busy=0, go never asserted; retrigger runs a full normal sequence.
- Random mode, SEED=16'hACE1, DLY_W=7:
  - hold length equals the bench reference LFSR's lfsr[6:0]+1 at HOLD entry.
  - across 20 runs, delays are not all equal and none exceeds 128 cycles.
- Boundaries:
  - delay_in=0 -> HOLD lasts exactly 1 cycle.
  - delay_in=127 -> 128 cycles.
  - trigger during HOLD is ignored.
  - rst asserted during FILL returns to IDLE with no go pulse.

Source files
------------

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills WIDTH lamps one per enable tick, holds them
// for a fixed or LFSR-derived delay, then blanks them and pulses go.
module f1_light_seq #(
    parameter int          WIDTH = 8,
    parameter int          DLY_W = 7,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trigger,
    input  logic             abort,
    input  logic             rnd_mode,
    input  logic [DLY_W-1:0] delay_in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             go
);

    localparam int              LIT_W     = $clog2(WIDTH + 1);
    localparam logic [15:0]     LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [LIT_W-1:0] LIT_LAST = LIT_W'(WIDTH - 1);
    localparam logic [LIT_W-1:0] LIT_FULL = LIT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_GO   = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [LIT_W-1:0] lit_r, lit_s;
    logic [DLY_W-1:0] hold_r, hold_s;
    logic [15:0]      lfsr_r;
    logic [WIDTH-1:0] out_s;
    logic             busy_s;
    logic             go_s;

    // x^16+x^14+x^13+x^11+1, shifting toward the LSB; a non-zero state never maps to zero
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [WIDTH-1:0] fill_mask(input logic [LIT_W-1:0] n);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    // Next-state logic for the sequencer; abort takes priority over en and hold expiry
    always_comb begin
        state_s = state_r;
        lit_s   = lit_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger) begin
                    state_s = ST_FILL;
                    lit_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    lit_s   = '0;
                end else if (en) begin
                    if (lit_r == LIT_LAST) begin
                        state_s = ST_HOLD;
                        lit_s   = LIT_FULL;
                        hold_s  = rnd_mode ? lfsr_r[DLY_W-1:0] : delay_in;
                    end else begin
                        lit_s = lit_r + LIT_W'(1);
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    lit_s   = '0;
                end else if (hold_r == '0) begin
                    state_s = ST_GO;
                end else begin
                    hold_s = hold_r - DLY_W'(1);
                end
            end
            ST_GO: begin
                state_s = ST_IDLE;
                lit_s   = '0;
            end
            default: begin
                state_s = ST_IDLE;
                lit_s   = '0;
                hold_s  = '0;
            end
        endcase
    end

    // Output decode of the upcoming state so the registered outputs track state exactly
    always_comb begin
        out_s  = '0;
        busy_s = (state_s != ST_IDLE);
        go_s   = 1'b0;
        case (state_s)
            ST_IDLE: out_s = '0;
            ST_FILL: out_s = fill_mask(lit_s);
            ST_HOLD: out_s = '1;
            ST_GO:   go_s  = 1'b1;
            default: out_s = '0;
        endcase
    end

    // State, counters, LFSR and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lit_r   <= '0;
            hold_r  <= '0;
            lfsr_r  <= LFSR_INIT;
            out     <= '0;
            busy    <= 1'b0;
            go      <= 1'b0;
        end else begin
            state_r <= state_s;
            lit_r   <= lit_s;
            hold_r  <= hold_s;
            lfsr_r  <= lfsr_next(lfsr_r);
            out     <= out_s;
            busy    <= busy_s;
            go      <= go_s;
        end
    end

endmodule
